mem_be_sdp_init: RTL

- Parametrised simple-dual-port memory with per-byte write enables: one write port and one read port, both on a single clock.
- Adds the following:
  - configurable read latency with a read-valid output;
  - optional same-cycle write-to-read forwarding;
  - out-of-range address protection;
  - a hardware init/clear sequencer that zeroes the whole array after reset or on request.
- Used as the generic register-file / scratch RAM primitive for core-side buffers.

---
 rtl/mem_be_sdp_init.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_be_sdp_init.sv
// Simple-dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// optional same-cycle write forwarding, range-checked addressing and a zeroing init sweep.
module mem_be_sdp_init #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter bit          WR_FWD = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       IN_clear,
  output logic                       OUT_ready,
  input  logic                       IN_we,
  input  logic [ADDR_W-1:0]          IN_waddr,
  input  logic [DATA_W-1:0]          IN_wdata,
  input  logic [DATA_W/BYTE_W-1:0]   IN_wmask,
  input  logic                       IN_re,
  input  logic [ADDR_W-1:0]          IN_raddr,
  output logic                       OUT_rvalid,
  output logic [DATA_W-1:0]          OUT_rdata
);

  localparam int unsigned NB   = DATA_W / BYTE_W;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IdxW-1:0]   CntLast = IdxW'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthA  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_in_range, rd_in_range;
  logic              mem_we;
  logic [IdxW-1:0]   mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] rd_data;
  logic              rd_take;

  logic              v1_q, v1_d;
  logic [DATA_W-1:0] d1_q, d1_d;

  assign run         = (state_q == StRun);
  assign OUT_ready   = run;
  assign wr_in_range = ({1'b0, IN_waddr} < DepthA);
  assign rd_in_range = ({1'b0, IN_raddr} < DepthA);
  assign rd_take     = run && IN_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        if (cnt_q == CntLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (IN_clear) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The init sweep owns the write port; user writes are ignored until RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = cnt_q;
    mem_wdata = '0;
    mem_be    = '0;
    if (!run) begin
      mem_we = 1'b1;
      mem_be = '1;
    end else if (IN_we && wr_in_range) begin
      mem_we    = 1'b1;
      mem_idx   = IN_waddr[IdxW-1:0];
      mem_wdata = IN_wdata;
      mem_be    = IN_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_idx][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem_q[IN_raddr[IdxW-1:0]];
      if (WR_FWD && IN_we && wr_in_range && (IN_waddr == IN_raddr)) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (IN_wmask[i]) begin
            rd_data[i*BYTE_W +: BYTE_W] = IN_wdata[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Read data is captured at the request edge, so later writes cannot disturb it.
  always_comb begin
    v1_d = rd_take;
    d1_d = rd_take ? rd_data : d1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] d2_q, d2_d;

    always_comb begin
      v2_d = v1_q;
      d2_d = v1_q ? d1_q : d2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign OUT_rvalid = v2_q;
    assign OUT_rdata  = d2_q;
  end else begin : g_lat1
    assign OUT_rvalid = v1_q;
    assign OUT_rdata  = d1_q;
  end

endmodule
